// File: rtl/ram_write_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// ram_write_arbiter_pkg
// Shared definitions for the two-requester RAM write arbiter:
//   - arb_state_t      : FSM state encoding (IDLE / OWN0 / OWN1)
//   - DEFAULT_MAX_HOLD : default cap on the number of cycles a locked owner
//                        may keep the write port
//   - HOLD_COUNT_WIDTH : width of the hold counter (covers MAX_HOLD 1..15)
//   - otherIndex()     : returns the other requester's index
// ---------------------------------------------------------------------------
package ram_write_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  localparam int DEFAULT_MAX_HOLD = 4;
  localparam int HOLD_COUNT_WIDTH = 4;

  // With only two requesters, "the other one" is simply the inverted index.
  function automatic logic otherIndex(input logic idx);
    return ~idx;
  endfunction

endpackage

// File: rtl/ram_write_arbiter_hold_counter.sv
// ---------------------------------------------------------------------------
// hold_counter
// Counts how long a locked owner has held the write port.
// Ports:
//   Clock     : rising-edge clock
//   Reset     : asynchronous active-high reset, clears the count to 0
//   iLoad     : synchronous load of the value 1 (has priority over iEnable)
//   iEnable   : increment the count by one
//   oTerminal : high while the count equals MAX_HOLD
// ---------------------------------------------------------------------------
module hold_counter #(
  parameter int MAX_HOLD = 4,
  parameter int WIDTH    = 4
) (
  input  logic Clock,
  input  logic Reset,
  input  logic iLoad,
  input  logic iEnable,
  output logic oTerminal
);

  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);
  localparam logic [WIDTH-1:0] TERMINAL = WIDTH'(MAX_HOLD);

  logic [WIDTH-1:0] r_count;

  // Load-1 marks the beat that took ownership; each further cycle counts up.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_count <= '0;
    end else if (iLoad) begin
      r_count <= ONE;
    end else if (iEnable) begin
      r_count <= r_count + ONE;
    end
  end

  assign oTerminal = (r_count == TERMINAL);

endmodule

// File: rtl/ram_write_arbiter.sv
// ---------------------------------------------------------------------------
// ram_write_arbiter
// Arbitrates two write requesters onto a single registered RAM write port.
// Round-robin between the requesters while IDLE; a requester that asserts its
// lock while transferring keeps the port (OWN0/OWN1) until it drops the lock
// or has held the port for MAX_HOLD cycles.
// Ports:
//   Clock, Reset               : clock, asynchronous active-high reset
//   iValid0/1, iAddr0/1,
//   iData0/1, iLock0/1         : requester write request, address, data, lock
//   oReady0/1                  : requester granted this cycle (combinational)
//   oWriteEnable/Address/Data  : registered RAM write port
//   oOwner                     : requester whose beat is on the write port
//   oLocked                    : high while in OWN0 or OWN1
// ---------------------------------------------------------------------------
module ram_write_arbiter
  import ram_write_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8,
  parameter int MAX_HOLD   = DEFAULT_MAX_HOLD
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  iValid0,
  input  logic                  iValid1,
  input  logic [ADDR_WIDTH-1:0] iAddr0,
  input  logic [ADDR_WIDTH-1:0] iAddr1,
  input  logic [DATA_WIDTH-1:0] iData0,
  input  logic [DATA_WIDTH-1:0] iData1,
  input  logic                  iLock0,
  input  logic                  iLock1,
  output logic                  oReady0,
  output logic                  oReady1,
  output logic                  oWriteEnable,
  output logic [ADDR_WIDTH-1:0] oWriteAddress,
  output logic [DATA_WIDTH-1:0] oWriteData,
  output logic                  oOwner,
  output logic                  oLocked
);

  arb_state_t            r_state;
  logic                  r_pointer;
  logic                  r_locked;
  logic                  r_writeEnable;
  logic [ADDR_WIDTH-1:0] r_writeAddress;
  logic [DATA_WIDTH-1:0] r_writeData;
  logic                  r_owner;

  logic w_ready0;
  logic w_ready1;
  logic w_xfer0;
  logic w_xfer1;
  logic w_holdLoad;
  logic w_holdEnable;
  logic w_holdTerminal;

  // Grant logic. In IDLE the round-robin pointer's requester wins if it is
  // valid, otherwise the other one may take the slot. While owned, only the
  // owner can be ready. Reset forces both grants low so nothing transfers.
  always_comb begin
    w_ready0 = 1'b0;
    w_ready1 = 1'b0;
    if (!Reset) begin
      case (r_state)
        IDLE: begin
          if (r_pointer == 1'b0) begin
            if (iValid0)      w_ready0 = 1'b1;
            else if (iValid1) w_ready1 = 1'b1;
          end else begin
            if (iValid1)      w_ready1 = 1'b1;
            else if (iValid0) w_ready0 = 1'b1;
          end
        end
        OWN0:    w_ready0 = iValid0;
        OWN1:    w_ready1 = iValid1;
        default: begin
          w_ready0 = 1'b0;
          w_ready1 = 1'b0;
        end
      endcase
    end
  end

  assign w_xfer0 = iValid0 & w_ready0;
  assign w_xfer1 = iValid1 & w_ready1;

  // The counter starts at 1 on the locking beat and then advances every
  // owned cycle, regardless of whether the owner transfers.
  assign w_holdLoad   = (r_state == IDLE) & ((w_xfer0 & iLock0) | (w_xfer1 & iLock1));
  assign w_holdEnable = (r_state != IDLE);

  hold_counter #(
    .MAX_HOLD (MAX_HOLD),
    .WIDTH    (HOLD_COUNT_WIDTH)
  ) u_holdCounter (
    .Clock     (Clock),
    .Reset     (Reset),
    .iLoad     (w_holdLoad),
    .iEnable   (w_holdEnable),
    .oTerminal (w_holdTerminal)
  );

  // Ownership FSM with the round-robin pointer and the registered lock flag.
  // Leaving an owned state hands priority to the other requester, and a beat
  // in the leaving cycle still transfers since oReady follows iValid there.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state   <= IDLE;
      r_pointer <= 1'b0;
      r_locked  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_xfer0) begin
            r_pointer <= otherIndex(1'b0);
            if (iLock0) begin
              r_state  <= OWN0;
              r_locked <= 1'b1;
            end
          end else if (w_xfer1) begin
            r_pointer <= otherIndex(1'b1);
            if (iLock1) begin
              r_state  <= OWN1;
              r_locked <= 1'b1;
            end
          end
        end
        OWN0: begin
          if (!iLock0 || w_holdTerminal) begin
            r_state   <= IDLE;
            r_pointer <= otherIndex(1'b0);
            r_locked  <= 1'b0;
          end
        end
        OWN1: begin
          if (!iLock1 || w_holdTerminal) begin
            r_state   <= IDLE;
            r_pointer <= otherIndex(1'b1);
            r_locked  <= 1'b0;
          end
        end
        default: begin
          r_state  <= IDLE;
          r_locked <= 1'b0;
        end
      endcase
    end
  end

  // Single write-port register stage: the strobe pulses for one cycle per
  // transfer, while address, data and owner keep the last written beat.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_writeEnable  <= 1'b0;
      r_writeAddress <= '0;
      r_writeData    <= '0;
      r_owner        <= 1'b0;
    end else begin
      r_writeEnable <= w_xfer0 | w_xfer1;
      if (w_xfer0) begin
        r_writeAddress <= iAddr0;
        r_writeData    <= iData0;
        r_owner        <= 1'b0;
      end else if (w_xfer1) begin
        r_writeAddress <= iAddr1;
        r_writeData    <= iData1;
        r_owner        <= 1'b1;
      end
    end
  end

  assign oReady0       = w_ready0;
  assign oReady1       = w_ready1;
  assign oWriteEnable  = r_writeEnable;
  assign oWriteAddress = r_writeAddress;
  assign oWriteData    = r_writeData;
  assign oOwner        = r_owner;
  assign oLocked       = r_locked;

endmodule

// File: tb/tb_ram_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ram_write_arbiter
// Directed bench for ram_write_arbiter (default parameters). Each stimulus
// cycle checks the grants and lock flag, and queues the write it expects;
// a separate monitor pops and compares on every write strobe.
// ---------------------------------------------------------------------------
module tb_ram_write_arbiter;

  typedef struct packed {
    logic [7:0]  addr;
    logic [15:0] data;
    logic        owner;
  } wr_t;

  logic        Clock;
  logic        Reset;
  logic        iValid0, iValid1;
  logic [7:0]  iAddr0, iAddr1;
  logic [15:0] iData0, iData1;
  logic        iLock0, iLock1;
  logic        oReady0, oReady1;
  logic        oWriteEnable;
  logic [7:0]  oWriteAddress;
  logic [15:0] oWriteData;
  logic        oOwner;
  logic        oLocked;

  int  checks = 0;
  int  errors = 0;
  wr_t expQ[$];

  ram_write_arbiter dut (
    .Clock         (Clock),
    .Reset         (Reset),
    .iValid0       (iValid0),
    .iValid1       (iValid1),
    .iAddr0        (iAddr0),
    .iAddr1        (iAddr1),
    .iData0        (iData0),
    .iData1        (iData1),
    .iLock0        (iLock0),
    .iLock1        (iLock1),
    .oReady0       (oReady0),
    .oReady1       (oReady1),
    .oWriteEnable  (oWriteEnable),
    .oWriteAddress (oWriteAddress),
    .oWriteData    (oWriteData),
    .oOwner        (oOwner),
    .oLocked       (oLocked)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Compare one observed value against the bench's expectation.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Drive one cycle of requests from a falling edge, check grants and lock,
  // queue the write the granted requester should produce, then move on.
  task automatic applyStimulus(
    input string name,
    input logic v0, input logic [7:0] a0, input logic [15:0] d0, input logic lk0,
    input logic v1, input logic [7:0] a1, input logic [15:0] d1, input logic lk1,
    input logic expR0, input logic expR1, input logic expLocked);
    iValid0 = v0; iAddr0 = a0; iData0 = d0; iLock0 = lk0;
    iValid1 = v1; iAddr1 = a1; iData1 = d1; iLock1 = lk1;
    #1;
    checkOutput({name, "_ready0"}, 32'(oReady0), 32'(expR0));
    checkOutput({name, "_ready1"}, 32'(oReady1), 32'(expR1));
    checkOutput({name, "_locked"}, 32'(oLocked), 32'(expLocked));
    if (expR0 && v0)      expQ.push_back('{addr: a0, data: d0, owner: 1'b0});
    else if (expR1 && v1) expQ.push_back('{addr: a1, data: d1, owner: 1'b1});
    @(negedge Clock);
  endtask

  // Write monitor: every strobe must match the oldest queued expectation.
  always @(negedge Clock) begin
    if (!Reset && oWriteEnable) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_write: got %0h/%0h owner %0d, expected no write",
                 oWriteAddress, oWriteData, oOwner);
      end else begin
        wr_t exp;
        exp = expQ.pop_front();
        checks++;
        if (oWriteAddress !== exp.addr || oWriteData !== exp.data || oOwner !== exp.owner) begin
          errors++;
          $display("[TB] FAIL write: got %0h/%0h owner %0d, expected %0h/%0h owner %0d",
                   oWriteAddress, oWriteData, oOwner, exp.addr, exp.data, exp.owner);
        end
      end
    end
  end

  initial begin
    Reset = 1'b1;
    iValid0 = 1'b1; iValid1 = 1'b1;
    iAddr0 = 8'h00; iAddr1 = 8'h00;
    iData0 = 16'h0; iData1 = 16'h0;
    iLock0 = 1'b0;  iLock1 = 1'b0;
    #1;
    checkOutput("rst_we",     32'(oWriteEnable),  32'd0);
    checkOutput("rst_addr",   32'(oWriteAddress), 32'd0);
    checkOutput("rst_data",   32'(oWriteData),    32'd0);
    checkOutput("rst_owner",  32'(oOwner),        32'd0);
    checkOutput("rst_locked", 32'(oLocked),       32'd0);
    checkOutput("rst_ready0", 32'(oReady0),       32'd0);
    checkOutput("rst_ready1", 32'(oReady1),       32'd0);
    @(negedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
    iValid0 = 1'b0; iValid1 = 1'b0;

    // Both valid, no lock: grants alternate starting with requester 0.
    for (int i = 0; i < 4; i++)
      applyStimulus("rr", 1'b1, 8'h10, 16'h00AA, 1'b0, 1'b1, 8'h20, 16'h00BB, 1'b0,
                    (i % 2) == 0, (i % 2) == 1, 1'b0);
    applyStimulus("idle", 1'b0, 8'h00, 16'h0, 1'b0, 1'b0, 8'h00, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("hold_we",    32'(oWriteEnable),  32'd0);
    checkOutput("hold_addr",  32'(oWriteAddress), 32'h20);
    checkOutput("hold_data",  32'(oWriteData),    32'h00BB);
    checkOutput("hold_owner", 32'(oOwner),        32'd1);

    // Locked owner 0: locking beat in IDLE, then MAX_HOLD owned cycles.
    applyStimulus("lock_take", 1'b1, 8'h30, 16'hC000, 1'b1, 1'b1, 8'h40, 16'hD000, 1'b0,
                  1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 4; i++)
      applyStimulus("lock_own", 1'b1, 8'h30, 16'hC000 + 16'(i), 1'b1, 1'b1, 8'h40, 16'hD000, 1'b0,
                    1'b1, 1'b0, 1'b1);
    applyStimulus("lock_after", 1'b1, 8'h30, 16'hC0FF, 1'b1, 1'b1, 8'h40, 16'hD001, 1'b0,
                  1'b0, 1'b1, 1'b0);
    applyStimulus("idle", 1'b0, 8'h00, 16'h0, 1'b0, 1'b0, 8'h00, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Owner 0 drops its lock on its second beat; that beat still writes.
    applyStimulus("drop_take", 1'b1, 8'h50, 16'h5001, 1'b1, 1'b1, 8'h60, 16'h6001, 1'b0,
                  1'b1, 1'b0, 1'b0);
    applyStimulus("drop_beat", 1'b1, 8'h50, 16'h5002, 1'b0, 1'b1, 8'h60, 16'h6001, 1'b0,
                  1'b1, 1'b0, 1'b1);
    applyStimulus("drop_next", 1'b1, 8'h50, 16'h5003, 1'b0, 1'b1, 8'h60, 16'h6002, 1'b0,
                  1'b0, 1'b1, 1'b0);
    applyStimulus("idle", 1'b0, 8'h00, 16'h0, 1'b0, 1'b0, 8'h00, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Requester 1 locks, then reset lands mid-cycle on an owned beat.
    applyStimulus("own1_take", 1'b0, 8'h00, 16'h0, 1'b0, 1'b1, 8'h70, 16'h7001, 1'b1,
                  1'b0, 1'b1, 1'b0);
    applyStimulus("own1_beat", 1'b1, 8'h01, 16'h0101, 1'b0, 1'b1, 8'h70, 16'h7002, 1'b1,
                  1'b0, 1'b1, 1'b1);
    iValid0 = 1'b0; iValid1 = 1'b1; iAddr1 = 8'h70; iData1 = 16'h7003; iLock1 = 1'b1;
    #1;
    checkOutput("pre_rst_ready1", 32'(oReady1), 32'd1);
    checkOutput("pre_rst_locked", 32'(oLocked), 32'd1);
    #1;
    Reset = 1'b1;
    #1;
    checkOutput("mid_rst_we",     32'(oWriteEnable), 32'd0);
    checkOutput("mid_rst_locked", 32'(oLocked),      32'd0);
    checkOutput("mid_rst_ready1", 32'(oReady1),      32'd0);
    @(negedge Clock);
    Reset = 1'b0;
    applyStimulus("post_rst", 1'b1, 8'h80, 16'h8001, 1'b0, 1'b1, 8'h90, 16'h9001, 1'b0,
                  1'b1, 1'b0, 1'b0);

    // Pointer now 1: a lone requester 1 grant returns it to 0, then a lone
    // requester 1 is granted even though the pointer favours requester 0.
    applyStimulus("solo1_a", 1'b0, 8'h00, 16'h0, 1'b0, 1'b1, 8'hA0, 16'hA001, 1'b0,
                  1'b0, 1'b1, 1'b0);
    applyStimulus("solo1_b", 1'b0, 8'h00, 16'h0, 1'b0, 1'b1, 8'hA1, 16'hA002, 1'b0,
                  1'b0, 1'b1, 1'b0);
    applyStimulus("ptr_zero", 1'b1, 8'hB0, 16'hB001, 1'b0, 1'b1, 8'hB1, 16'hB002, 1'b0,
                  1'b1, 1'b0, 1'b0);

    applyStimulus("idle", 1'b0, 8'h00, 16'h0, 1'b0, 1'b0, 8'h00, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus("idle", 1'b0, 8'h00, 16'h0, 1'b0, 1'b0, 8'h00, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("queue_drained", 32'(expQ.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_write_arbiter.md
RAM_WRITE_ARBITER -- requirements
Module: ram_write_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 16: width of the write data.
REQ-002 Parameter ADDR_WIDTH, default 8: width of the write address.
REQ-003 Parameter MAX_HOLD, default 4, legal range 1..15: the maximum number of cycles a locked owner may keep the port.
REQ-004 Port Clock, input, 1 bit: single clock; all state is updated on the rising edge.
REQ-005 Port Reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 Ports iValid0/iValid1, input, 1 bit each: requester n has a write pending.
REQ-007 Ports iAddr0/iAddr1, input, ADDR_WIDTH each: write address for requester n.
REQ-008 Ports iData0/iData1, input, DATA_WIDTH each: write data for requester n.
REQ-009 Ports iLock0/iLock1, input, 1 bit each: requester n asks to keep ownership after its current beat.
REQ-010 Ports oReady0/oReady1, output, 1 bit each: requester n is granted this cycle.
REQ-011 Port oWriteEnable, output, 1 bit: registered write strobe to the data RAM write port.
REQ-012 Port oWriteAddress, output, ADDR_WIDTH: registered write address.
REQ-013 Port oWriteData, output, DATA_WIDTH: registered write data.
REQ-014 Port oOwner, output, 1 bit: index of the requester whose beat is currently on the write port.
REQ-015 Port oLocked, output, 1 bit: high while the FSM is in OWN0 or OWN1.

Function
REQ-016 A transfer SHALL occur for requester n in any cycle where iValidn and oReadyn are both high.
REQ-017 The FSM SHALL have exactly three states: IDLE, OWN0, OWN1.
REQ-018 In IDLE, oReady SHALL be combinational:
  - the round-robin pointer's requester is ready if its iValid is high;
  - otherwise the other requester is ready if its iValid is high;
  - the two oReady outputs are never high together.
REQ-019 In OWNn, only oReadyn SHALL be asserted, and it SHALL equal iValidn.
REQ-020 On an IDLE transfer by requester n:
  - the round-robin pointer SHALL become the other index;
  - if iLockn is high, the next state SHALL be OWNn and the hold counter SHALL load 1;
  - otherwise the FSM SHALL stay in IDLE.
REQ-021 In OWNn, the hold counter SHALL increment every cycle, whether or not a beat transfers.
REQ-022 OWNn SHALL return to IDLE, with the pointer set to the other index, on whichever comes first:
  - iLockn low (sampled in any cycle);
  - the hold counter equal to MAX_HOLD.
REQ-023 If iLockn is low in a cycle where requester n also transfers, that beat SHALL still be written, and the FSM SHALL be in IDLE in the next cycle.
REQ-024 On every transfer, oWriteEnable, oWriteAddress, oWriteData and oOwner SHALL update on the next rising edge. Latency is exactly 1 cycle.
REQ-025 In a cycle with no transfer, oWriteEnable SHALL be 0 on the next edge, and oWriteAddress, oWriteData and oOwner SHALL hold their previous values.
REQ-026 Throughput SHALL be one write per cycle, including a transfer in the same cycle as an OWN-to-IDLE transition.
REQ-027 When both requesters are valid in IDLE, the grant SHALL alternate cycle by cycle.

Reset
REQ-028 While Reset is high, the following SHALL be held immediately, independent of Clock:
  - state = IDLE, round-robin pointer = 0, hold counter = 0;
  - oWriteEnable = 0, oWriteAddress = 0, oWriteData = 0, oOwner = 0, oLocked = 0.
REQ-029 A Reset asserted during OWNn SHALL drop that ownership. No beat presented in that cycle SHALL be written.
REQ-030 oReady0 and oReady1 SHALL be 0 while Reset is high.

Structure
REQ-031 The state encoding (IDLE=2'd0, OWN0=2'd1, OWN1=2'd2) and the default MAX_HOLD SHALL live in the shared definitions include file.
REQ-032 The hold counter SHALL be one sub-module, hold_counter: asynchronous reset, synchronous load-1, enable, and a terminal-count output compared against MAX_HOLD.
REQ-033 The write-port output register SHALL be one asynchronous-reset register stage, with no further pipelining.

Verification
REQ-034 After reset, iValid0=1 (addr 8'h10, data 16'h00AA) and iValid1=1 (addr 8'h20, data 16'h00BB), both iLock=0, held for 4 cycles -> oReady alternates 0,1,0,1. Writes appear one cycle later: 10/AA, 20/BB, 10/AA, 20/BB.
REQ-035 iValid0=1 and iLock0=1 held with MAX_HOLD=4, iValid1=1 held -> requester 0 owns the port for exactly 4 beats. Requester 1 is then granted, and oLocked falls after the 4th beat.
REQ-036 In OWN0, iLock0 drops with iValid0=1 on its 2nd beat -> that beat is written, and the next cycle grants requester 1.
REQ-037 Reset is pulsed mid-cycle while in OWN1 with iValid1=1 -> oWriteEnable=0 and oLocked=0 immediately. No write occurs for that beat, and the pointer is 0 after release.
REQ-038 iValid1=1 only, while the pointer is 0 -> requester 1 is granted in the same cycle, oWriteEnable=1 on the next cycle, and the pointer becomes 0.
